// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   localparam int unsigned FRAME_BITS           = 10;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 1667;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      START = 2'd0,
      DATA  = 2'd1,
      STOP  = 2'd2
   } bit_phase_e;

   // Which part of the 8N1 frame a bit index falls in.
   function automatic bit_phase_e phase_of(input logic [3:0] idx);
      if (idx == 4'd0) begin
         return START;
      end else if (idx == 4'(FRAME_BITS - 1)) begin
         return STOP;
      end else begin
         return DATA;
      end
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Single-frame 8N1 shifter: start pulse in, one frame out, done on the last stop-bit cycle.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       CLR,
   input  logic       i_start,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_done
);

   localparam int unsigned    CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]     BIT_LAST = 4'(FRAME_BITS - 1);

   logic             r_active;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_bit;
   logic             r_tx;

   logic             w_bit_end;
   logic [3:0]       w_bit_next;
   logic             w_tx_next;

   // Bit boundary detection and the line level of the following bit.
   always_comb begin
      w_bit_end  = r_active && (r_cnt == CNT_LAST);
      o_done     = w_bit_end && (r_bit == BIT_LAST);
      w_bit_next = (r_bit == BIT_LAST) ? r_bit : r_bit + 4'd1;
      w_tx_next  = 1'b1;
      case (phase_of(w_bit_next))
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = i_data[3'(w_bit_next - 4'd1)];
         STOP:    w_tx_next = 1'b1;
         default: w_tx_next = 1'b1;
      endcase
   end

   // Baud counter, bit index and registered line; the start bit goes out the cycle after start.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         r_active <= 1'b0;
         r_cnt    <= '0;
         r_bit    <= 4'd0;
         r_tx     <= 1'b1;
      end else if (i_start && !r_active) begin
         r_active <= 1'b1;
         r_cnt    <= '0;
         r_bit    <= 4'd0;
         r_tx     <= 1'b0;
      end else if (r_active) begin
         if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == BIT_LAST) begin
               r_active <= 1'b0;
               r_tx     <= 1'b1;
            end else begin
               r_bit <= w_bit_next;
               r_tx  <= w_tx_next;
            end
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_tx = r_tx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line among NUM_REQ byte producers.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int unsigned NUM_REQ      = 4,
   parameter  int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   localparam int unsigned ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   CLR,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   input  logic [8*NUM_REQ-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]     o_req_ready,
   output logic                   o_tx,
   output logic                   o_busy,
   output logic [ID_W-1:0]        o_active_id
);

   arb_state_e      r_state;
   arb_state_e      w_state_next;
   logic            r_busy;
   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] r_active_id;
   logic [7:0]      r_hold;

   logic            w_grant_found;
   logic [ID_W-1:0] w_grant_idx;
   logic [7:0]      w_grant_data;
   logic [ID_W-1:0] w_ptr_next;
   logic            w_accept;
   logic            w_ser_done;

   // First valid requester at or above the pointer, wrapping; plus its byte.
   always_comb begin
      int unsigned v_sum;
      v_sum         = 0;
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      w_grant_data  = 8'h00;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         v_sum = 32'(r_ptr) + off;
         if (v_sum >= NUM_REQ) begin
            v_sum = v_sum - NUM_REQ;
         end
         if (!w_grant_found && i_req_valid[ID_W'(v_sum)]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = ID_W'(v_sum);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant_idx == ID_W'(i)) begin
            w_grant_data = i_req_data[8*i +: 8];
         end
      end
      w_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
   end

   // Controller next state; accepts only from IDLE and never while held in reset.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant_found && !CLR) begin
               w_accept     = 1'b1;
               w_state_next = SEND;
            end
         end
         SEND: begin
            if (w_ser_done) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // One-hot accept strobe in the grant cycle.
   always_comb begin
      o_req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         o_req_ready[i] = w_accept && (w_grant_idx == ID_W'(i));
      end
   end

   // Controller state and busy flag.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next == SEND);
      end
   end

   // Holding register, active index and round-robin pointer update on accept.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         r_hold      <= 8'h00;
         r_active_id <= '0;
         r_ptr       <= '0;
      end else if (w_accept) begin
         r_hold      <= w_grant_data;
         r_active_id <= w_grant_idx;
         r_ptr       <= w_ptr_next;
      end
   end

   uart_tx_serializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk     (clk),
      .CLR     (CLR),
      .i_start (w_accept),
      .i_data  (r_hold),
      .o_tx    (o_tx),
      .o_done  (w_ser_done)
   );

   assign o_busy      = r_busy;
   assign o_active_id = r_active_id;

endmodule
